axis_packet_master: RTL and testbench

//  Synthesisable, parametrised AXI4-Stream packet source. It collects words on a

---
 rtl/axis_packet_master.sv | 127 ++++++++++++
 tb/tb_axis_packet_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_master.sv
// AXI4-Stream packet source: words are queued in a FIFO through a push port,
// then a commit pulse emits the queued words as a single packet with optional inter-beat gaps.
module axis_packet_master #(
   parameter int DATA_W         = 32,
   parameter int DEST_W         = 8,
   parameter int USER_W         = 4,
   parameter int DEPTH          = 64,
   parameter int DEST_FROM_DATA = 1,
   parameter int GAP_W          = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_commit,
   input  logic [DEST_W-1:0]          cfg_dest,
   input  logic [GAP_W-1:0]           cfg_gap,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [DATA_W-1:0]          m_axis_tdata,
   output logic                       m_axis_tlast,
   output logic [DEST_W-1:0]          m_axis_tdest,
   output logic [USER_W-1:0]          m_axis_tuser,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                pkt_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t              state, next_state;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [LW-1:0]       count;
   logic                first;
   logic [DEST_W-1:0]   dest_q, dest_sel;
   logic [GAP_W-1:0]    gap_q, gap_cnt;
   logic [15:0]         pkt_q;
   logic [DATA_W-1:0]   head;
   logic                full, push, beat, last_word, start;

   assign head      = mem[rd_ptr];
   assign full      = (count == LW'(DEPTH));
   assign last_word = (count == LW'(1));
   assign push      = wr_valid & wr_ready;
   assign beat      = m_axis_tvalid & m_axis_tready;
   // An empty commit only starts a packet if a word is pushed in the same cycle.
   assign start     = (state == IDLE) & wr_commit & ((count != '0) | push);

   always_comb begin
      dest_sel = cfg_dest;
      if (DEST_FROM_DATA != 0)
         dest_sel = (count == '0) ? wr_data[DATA_W-1 -: DEST_W] : head[DATA_W-1 -: DEST_W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (start) next_state = SEND;
         SEND: begin
            if (beat) begin
               if (last_word)        next_state = IDLE;
               else if (gap_q != '0) next_state = GAP;
            end
         end
         GAP:  if (gap_cnt == GAP_W'(1)) next_state = SEND;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      wr_ready        = (state == IDLE) & ~full;
      m_axis_tvalid   = (state == SEND);
      m_axis_tdata    = (state == SEND) ? head : '0;
      m_axis_tlast    = (state == SEND) & last_word;
      m_axis_tuser    = '0;
      m_axis_tuser[0] = (state == SEND) & first;
      m_axis_tdest    = dest_q;
      busy            = (state != IDLE);
      level           = count;
      pkt_cnt         = pkt_q;
   end

   // Storage carries no reset; stale words are never visible because the pointers are cleared.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         first   <= 1'b0;
         dest_q  <= '0;
         gap_q   <= '0;
         gap_cnt <= '0;
         pkt_q   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (beat) begin
            rd_ptr <= rd_ptr + AW'(1);
            first  <= 1'b0;
         end
         if (push && !beat)      count <= count + LW'(1);
         else if (beat && !push) count <= count - LW'(1);
         if (start) begin
            first  <= 1'b1;
            gap_q  <= cfg_gap;
            dest_q <= dest_sel;
         end
         if (beat && !last_word && gap_q != '0) gap_cnt <= gap_q;
         else if (state == GAP)                 gap_cnt <= gap_cnt - GAP_W'(1);
         if (beat && last_word) pkt_q <= pkt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_axis_packet_master.sv
// Directed bench for axis_packet_master: one instance takes TDEST from data, a second from cfg_dest.
module tb_axis_packet_master;

   logic        clk = 1'b0;
   logic        rstN;
   logic        wrValid, wrReady, wrCommit;
   logic [31:0] wrData;
   logic [7:0]  cfgDest;
   logic [3:0]  cfgGap;
   logic        tvalid, tready, tlast, busy;
   logic [31:0] tdata;
   logic [7:0]  tdest;
   logic [3:0]  tuser;
   logic [4:0]  level;
   logic [15:0] pktCnt;

   logic        bWrValid, bWrReady, bWrCommit;
   logic [31:0] bWrData;
   logic [7:0]  bCfgDest;
   logic [3:0]  bCfgGap;
   logic        bTvalid, bTready, bTlast, bBusy;
   logic [31:0] bTdata;
   logic [7:0]  bTdest;
   logic [3:0]  bTuser;
   logic [2:0]  bLevel;
   logic [15:0] bPktCnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axis_packet_master #(.DATA_W(32), .DEST_W(8), .USER_W(4), .DEPTH(16),
                        .DEST_FROM_DATA(1), .GAP_W(4)) dutA (
      .clk(clk), .rst_n(rstN), .wr_valid(wrValid), .wr_ready(wrReady), .wr_data(wrData),
      .wr_commit(wrCommit), .cfg_dest(cfgDest), .cfg_gap(cfgGap),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
      .m_axis_tlast(tlast), .m_axis_tdest(tdest), .m_axis_tuser(tuser),
      .busy(busy), .level(level), .pkt_cnt(pktCnt));

   axis_packet_master #(.DATA_W(32), .DEST_W(8), .USER_W(4), .DEPTH(4),
                        .DEST_FROM_DATA(0), .GAP_W(4)) dutB (
      .clk(clk), .rst_n(rstN), .wr_valid(bWrValid), .wr_ready(bWrReady), .wr_data(bWrData),
      .wr_commit(bWrCommit), .cfg_dest(bCfgDest), .cfg_gap(bCfgGap),
      .m_axis_tvalid(bTvalid), .m_axis_tready(bTready), .m_axis_tdata(bTdata),
      .m_axis_tlast(bTlast), .m_axis_tdest(bTdest), .m_axis_tuser(bTuser),
      .busy(bBusy), .level(bLevel), .pkt_cnt(bPktCnt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] data);
      wrValid = 1'b1;
      wrData  = data;
      tick();
      wrValid = 1'b0;
   endtask

   task automatic commitPacket();
      wrCommit = 1'b1;
      tick();
      wrCommit = 1'b0;
   endtask

   initial begin
      int idx;
      int cyc;
      logic expV;

      rstN = 1'b0; wrValid = 1'b0; wrCommit = 1'b0; wrData = '0;
      cfgDest = '0; cfgGap = '0; tready = 1'b0;
      bWrValid = 1'b0; bWrCommit = 1'b0; bWrData = '0;
      bCfgDest = '0; bCfgGap = '0; bTready = 1'b1;
      tick();
      tick();
      checkOutput("rst_tvalid", 64'(tvalid), 64'(0));
      checkOutput("rst_level",  64'(level),  64'(0));
      checkOutput("rst_pkt",    64'(pktCnt), 64'(0));
      checkOutput("rst_busy",   64'(busy),   64'(0));
      checkOutput("rst_tdata",  64'(tdata),  64'(0));
      checkOutput("rst_tdest",  64'(tdest),  64'(0));
      checkOutput("rst_tuser",  64'(tuser),  64'(0));
      checkOutput("rst_tlast",  64'(tlast),  64'(0));
      rstN = 1'b1;
      tick();
      checkOutput("rst_wrready", 64'(wrReady), 64'(1));

      // Three-beat packet with TDEST taken from the first word.
      tready = 1'b1;
      applyStimulus(32'hA500_0001);
      applyStimulus(32'hA500_0002);
      applyStimulus(32'hA500_0003);
      checkOutput("t1_level", 64'(level), 64'(3));
      commitPacket();
      for (int i = 0; i < 3; i++) begin
         checkOutput("t1_tvalid", 64'(tvalid), 64'(1));
         checkOutput("t1_tdata",  64'(tdata),  64'(32'hA500_0001 + i));
         checkOutput("t1_tdest",  64'(tdest),  64'(8'hA5));
         checkOutput("t1_tuser",  64'(tuser),  64'((i == 0) ? 1 : 0));
         checkOutput("t1_tlast",  64'(tlast),  64'((i == 2) ? 1 : 0));
         tick();
      end
      checkOutput("t1_idle", 64'(tvalid), 64'(0));
      checkOutput("t1_pkt",  64'(pktCnt), 64'(1));

      // Single word pushed together with commit; TDEST from cfg_dest, latched at commit.
      bCfgDest = 8'h3C; bWrValid = 1'b1; bWrData = 32'h1234_5678; bWrCommit = 1'b1;
      tick();
      bWrValid = 1'b0; bWrCommit = 1'b0; bCfgDest = 8'h77;
      checkOutput("t2_tvalid", 64'(bTvalid), 64'(1));
      checkOutput("t2_tdata",  64'(bTdata),  64'(32'h1234_5678));
      checkOutput("t2_tdest",  64'(bTdest),  64'(8'h3C));
      checkOutput("t2_tuser",  64'(bTuser),  64'(1));
      checkOutput("t2_tlast",  64'(bTlast),  64'(1));
      tick();
      checkOutput("t2_idle", 64'(bTvalid), 64'(0));
      checkOutput("t2_pkt",  64'(bPktCnt), 64'(1));

      // Sixteen-beat packet with a fixed tready stall pattern.
      for (int i = 0; i < 16; i++) applyStimulus(32'h5A00_0000 + i);
      checkOutput("t3_full_level",   64'(level),   64'(16));
      checkOutput("t3_full_wrready", 64'(wrReady), 64'(0));
      tready = 1'b0;
      commitPacket();
      idx = 0;
      cyc = 0;
      while (idx < 16 && cyc < 200) begin
         checkOutput("t3_tvalid", 64'(tvalid), 64'(1));
         checkOutput("t3_tdata",  64'(tdata),  64'(32'h5A00_0000 + idx));
         checkOutput("t3_tlast",  64'(tlast),  64'((idx == 15) ? 1 : 0));
         checkOutput("t3_tdest",  64'(tdest),  64'(8'h5A));
         tready = ((cyc % 3) != 1);
         tick();
         if (tready) idx++;
         cyc++;
      end
      checkOutput("t3_done", 64'(idx), 64'(16));
      tready = 1'b1;
      checkOutput("t3_idle", 64'(tvalid), 64'(0));
      checkOutput("t3_pkt",  64'(pktCnt), 64'(2));

      // Four beats with a gap of three idle cycles, changed mid-packet to prove it is latched.
      cfgGap = 4'd3;
      for (int i = 0; i < 4; i++) applyStimulus(32'hB000_0000 + i);
      commitPacket();
      cfgGap = 4'd0;
      for (int k = 0; k < 14; k++) begin
         expV = ((k % 4) == 0) && (k <= 12);
         checkOutput("t4_tvalid", 64'(tvalid), 64'(expV));
         checkOutput("t4_busy",   64'(busy),   64'((k <= 12) ? 1 : 0));
         if (expV) begin
            checkOutput("t4_tdata", 64'(tdata), 64'(32'hB000_0000 + k / 4));
            checkOutput("t4_tlast", 64'(tlast), 64'((k == 12) ? 1 : 0));
         end
         tick();
      end
      checkOutput("t4_pkt", 64'(pktCnt), 64'(3));

      // Overflow: seventeen pushes, only sixteen kept.
      wrValid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wrData = 32'hC100_0000 + i;
         tick();
      end
      wrValid = 1'b0;
      checkOutput("t5_level",   64'(level),   64'(16));
      checkOutput("t5_wrready", 64'(wrReady), 64'(0));
      commitPacket();
      for (int i = 0; i < 16; i++) begin
         checkOutput("t5_tvalid", 64'(tvalid), 64'(1));
         checkOutput("t5_tdata",  64'(tdata),  64'(32'hC100_0000 + i));
         checkOutput("t5_tlast",  64'(tlast),  64'((i == 15) ? 1 : 0));
         tick();
      end
      checkOutput("t5_idle",  64'(tvalid), 64'(0));
      checkOutput("t5_empty", 64'(level),  64'(0));
      checkOutput("t5_pkt",   64'(pktCnt), 64'(4));
      commitPacket();
      checkOutput("t5_empty_commit_busy",   64'(busy),   64'(0));
      checkOutput("t5_empty_commit_tvalid", 64'(tvalid), 64'(0));

      // Reset during beat two of five, then a fresh packet.
      for (int i = 0; i < 5; i++) applyStimulus(32'hD000_0000 + i);
      commitPacket();
      checkOutput("t6_beat1", 64'(tdata), 64'(32'hD000_0000));
      tick();
      checkOutput("t6_beat2", 64'(tdata), 64'(32'hD000_0001));
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      checkOutput("t6_tvalid", 64'(tvalid), 64'(0));
      checkOutput("t6_level",  64'(level),  64'(0));
      checkOutput("t6_pkt",    64'(pktCnt), 64'(0));
      checkOutput("t6_busy",   64'(busy),   64'(0));
      applyStimulus(32'hE000_0001);
      applyStimulus(32'hE000_0002);
      commitPacket();
      checkOutput("t6_new_tuser", 64'(tuser), 64'(1));
      checkOutput("t6_new_tdata", 64'(tdata), 64'(32'hE000_0001));
      checkOutput("t6_new_tdest", 64'(tdest), 64'(8'hE0));
      tick();
      checkOutput("t6_new_tlast", 64'(tlast), 64'(1));
      tick();
      checkOutput("t6_new_pkt", 64'(pktCnt), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
